// File: rtl/azadi_uart_sink_pkg.sv
// Shared types and constants for the UART receive sink.
package azadi_uart_sink_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_sink_state_e;

    localparam int unsigned MIN_CLKS_PER_BIT = 2;
    localparam int unsigned UART_DATA_W      = 8;

    // Effective bit period: anything below the minimum is raised to it so
    // the half-bit start sample point never underflows.
    function automatic logic [15:0] eff_div(input logic [15:0] clks_per_bit);
        if (clks_per_bit < 16'(MIN_CLKS_PER_BIT)) begin
            return 16'(MIN_CLKS_PER_BIT);
        end
        return clks_per_bit;
    endfunction

endpackage

// File: rtl/azadi_uart_sink_fifo.sv
// Synchronous FIFO: registered push/pop, head presented combinationally from
// storage, no fall-through (a push into an empty FIFO is visible next cycle).
module azadi_uart_sink_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    level_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level_reg == '0);
    assign full    = (level_reg == LW'(DEPTH));
    assign level   = level_reg;
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    // Head is forced to zero while empty so stale storage never leaks out.
    assign rdata   = empty ? '0 : mem[rd_ptr_reg];

    // Storage write; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; level tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/azadi_uart_sink.sv
// UART 8N1 receive sink: synchroniser, oversampling deserialiser FSM,
// receive FIFO with valid/ready output, sticky framing/overflow flags.
module azadi_uart_sink #(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          rx_i,
    input  logic [15:0]                   clks_per_bit_i,
    output logic [7:0]                    rx_data_o,
    output logic                          rx_valid_o,
    input  logic                          rx_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          busy_o,
    output logic                          frame_err_o,
    output logic                          overflow_o,
    input  logic                          err_clr_i
);

    import azadi_uart_sink_pkg::*;

    logic                   sync_reg [SYNC_STAGES];
    logic                   rxs;
    logic                   rxs_prev_reg;

    uart_sink_state_e       state_reg, state_next;
    logic [15:0]            clk_cnt_reg, clk_cnt_next;
    logic [15:0]            div_reg, div_next;
    logic [15:0]            half_div;
    logic [2:0]             bit_cnt_reg, bit_cnt_next;
    logic [UART_DATA_W-1:0] shift_reg, shift_next;
    logic                   push_reg, push_next;
    logic                   frame_err_set;
    logic                   frame_err_reg;
    logic                   overflow_reg;
    logic                   overflow_set;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;

    // Input synchroniser chain; flops reset high so reset release is not a start edge.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) sync_reg[gi] <= 1'b1;
                    else         sync_reg[gi] <= rx_i;
                end
            end else begin : g_rest
                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) sync_reg[gi] <= 1'b1;
                    else         sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign rxs      = sync_reg[SYNC_STAGES-1];
    assign half_div = div_reg >> 1;

    // FSM state, counters, shift register and the delayed push strobe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= IDLE;
            clk_cnt_reg  <= '0;
            div_reg      <= 16'(MIN_CLKS_PER_BIT);
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            push_reg     <= 1'b0;
            rxs_prev_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            clk_cnt_reg  <= clk_cnt_next;
            div_reg      <= div_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            push_reg     <= push_next;
            rxs_prev_reg <= rxs;
        end
    end

    // Next-state logic: start detect, half-bit start check, data bits, stop check, break wait.
    always_comb begin
        state_next    = state_reg;
        clk_cnt_next  = clk_cnt_reg;
        div_next      = div_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        push_next     = 1'b0;
        frame_err_set = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rxs_prev_reg && !rxs) begin
                    state_next   = START;
                    clk_cnt_next = '0;
                    // Bit period is frozen for the whole frame from here on.
                    div_next     = eff_div(clks_per_bit_i);
                end
            end
            START: begin
                if (clk_cnt_reg == half_div - 16'd1) begin
                    clk_cnt_next = '0;
                    if (!rxs) begin
                        state_next   = DATA;
                        bit_cnt_next = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + 16'd1;
                end
            end
            DATA: begin
                if (clk_cnt_reg == div_reg - 16'd1) begin
                    clk_cnt_next = '0;
                    shift_next   = {rxs, shift_reg[UART_DATA_W-1:1]};
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + 16'd1;
                end
            end
            STOP: begin
                if (clk_cnt_reg == div_reg - 16'd1) begin
                    clk_cnt_next = '0;
                    if (rxs) begin
                        push_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_err_set = 1'b1;
                        state_next    = BREAK;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + 16'd1;
                end
            end
            BREAK: begin
                // A line held low stays here, so it reports only one error.
                if (rxs) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    azadi_uart_sink_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (push_reg),
        .pop   (pop),
        .wdata (shift_reg),
        .rdata (rx_data_o),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level_o)
    );

    assign rx_valid_o   = !fifo_empty;
    assign pop          = rx_valid_o && rx_ready_i;
    assign overflow_set = push_reg && fifo_full && !pop;
    assign busy_o       = (state_reg != IDLE);
    assign frame_err_o  = frame_err_reg;
    assign overflow_o   = overflow_reg;

    // Sticky error flags; a new event beats a simultaneous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_err_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            if (frame_err_set)  frame_err_reg <= 1'b1;
            else if (err_clr_i) frame_err_reg <= 1'b0;
            if (overflow_set)   overflow_reg  <= 1'b1;
            else if (err_clr_i) overflow_reg  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_azadi_uart_sink.sv
// Scoreboard bench for azadi_uart_sink: stimulus pushes expected bytes,
// an independent monitor pops and compares on every valid&&ready handshake.
module tb_azadi_uart_sink;

    localparam int DEPTH = 16;
    localparam int LW    = 5;
    localparam int BIT   = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx;
    logic [15:0]   cpb;
    logic          ready;
    logic          err_clr;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [LW-1:0] level;
    logic          busy;
    logic          frame_err;
    logic          overflow;

    int         checks = 0;
    int         failures = 0;
    int         valid_cycles = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    azadi_uart_sink #(
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .rx_i           (rx),
        .clks_per_bit_i (cpb),
        .rx_data_o      (rx_data),
        .rx_valid_o     (rx_valid),
        .rx_ready_i     (ready),
        .fifo_level_o   (level),
        .busy_o         (busy),
        .frame_err_o    (frame_err),
        .overflow_o     (overflow),
        .err_clr_i      (err_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end else begin
            $display("ok   %s value=0x%0h", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive nbits of a frame (LSB first: start, data[0..7], stop), bitlen clocks each.
    task automatic send_bits(input logic [9:0] frame, input int nbits, input int bitlen);
        for (int i = 0; i < nbits; i++) begin
            rx = frame[i];
            tick(bitlen);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input int bitlen, input bit expect_push);
        if (expect_push) exp_q.push_back(d);
        send_bits({1'b1, d, 1'b0}, 10, bitlen);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            tick(1);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    // Monitor: every accepted byte is compared against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (rx_valid === 1'b1) valid_cycles++;
            if (rx_valid === 1'b1 && ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pop_unexpected actual=0x%0h required=no_byte", rx_data);
                end else begin
                    check("pop_data", rx_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        rst_n   = 1'b0;
        rx      = 1'b1;
        cpb     = 16'(BIT);
        ready   = 1'b0;
        err_clr = 1'b0;
        tick(3);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_level", level, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        tick(3);

        // Single byte 0xA5 with the consumer always ready.
        ready = 1'b1;
        valid_cycles = 0;
        send_byte(8'hA5, BIT, 1'b1);
        tick(10);
        wait_drain("t1_drain");
        check("t1_valid_cycles", valid_cycles, 1);
        check("t1_busy", busy, 0);
        check("t1_frame_err", frame_err, 0);
        check("t1_overflow", overflow, 0);

        // Low pulse shorter than half a bit: start rejected as a glitch.
        rx = 1'b0;
        tick(5);
        check("t2_busy_mid", busy, 1);
        tick(1);
        rx = 1'b1;
        tick(40);
        check("t2_busy", busy, 0);
        check("t2_level", level, 0);
        check("t2_frame_err", frame_err, 0);

        // 0x3C with a low stop bit, line then held low for 40 bits.
        send_bits({1'b0, 8'h3C, 1'b0}, 10, BIT);
        tick(BIT * 20);
        check("t3_frame_err", frame_err, 1);
        check("t3_level", level, 0);
        check("t3_busy_break", busy, 1);
        pulse_clr();
        check("t3_clr", frame_err, 0);
        tick(BIT * 19);
        check("t3_single_error", frame_err, 0);
        rx = 1'b1;
        tick(10);
        check("t3_busy_after", busy, 0);
        check("t3_level_after", level, 0);

        // 17 bytes into a 16-deep FIFO with no consumer: the last is dropped.
        ready = 1'b0;
        for (int i = 0; i < 17; i++) send_byte(8'(i), BIT, (i < 16));
        tick(10);
        check("t4_level_full", level, 16);
        check("t4_overflow", overflow, 1);
        ready = 1'b1;
        wait_drain("t4_drain");
        tick(2);
        check("t4_level_empty", level, 0);
        pulse_clr();
        check("t4_overflow_clr", overflow, 0);

        // Full FIFO, consumer ready exactly in the cycle the 17th byte is pushed.
        ready = 1'b0;
        for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i), BIT, 1'b1);
        tick(5);
        check("t5_level_full", level, 16);
        fork
            send_byte(8'h30, BIT, 1'b1);
            begin
                int n = 0;
                while (busy !== 1'b1 && n < 200) begin tick(1); n++; end
                while (busy !== 1'b0 && n < 400) begin tick(1); n++; end
                check("t5_push_seen", (n < 400), 1);
                ready = 1'b1;
                tick(1);
                ready = 1'b0;
            end
        join
        tick(5);
        check("t5_level_stays", level, 16);
        check("t5_no_overflow", overflow, 0);
        ready = 1'b1;
        wait_drain("t5_drain");
        tick(2);
        check("t5_level_empty", level, 0);

        // Reset in the middle of 0x55 with two bytes queued.
        ready = 1'b0;
        send_byte(8'h40, BIT, 1'b1);
        send_byte(8'h41, BIT, 1'b1);
        tick(5);
        check("t6_level_two", level, 2);
        send_bits({1'b1, 8'h55, 1'b0}, 4, BIT);
        check("t6_busy_data", busy, 1);
        rst_n = 1'b0;
        rx    = 1'b1;
        exp_q.delete();
        tick(1);
        check("t6_rst_valid", rx_valid, 0);
        check("t6_rst_data", rx_data, 0);
        check("t6_rst_level", level, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_flags", {frame_err, overflow}, 0);
        rst_n = 1'b1;
        tick(3);
        // Divisor change mid-frame must not disturb the byte in flight.
        ready = 1'b1;
        fork
            send_byte(8'h81, BIT, 1'b1);
            begin
                tick(BIT * 2);
                cpb = 16'd3;
            end
        join
        cpb = 16'(BIT);
        tick(10);
        wait_drain("t6_drain");
        check("t6_busy_after", busy, 0);

        // Divisor below the minimum runs at two clocks per bit.
        cpb = 16'd0;
        send_byte(8'h6B, 2, 1'b1);
        tick(10);
        wait_drain("t7_drain");
        check("t7_frame_err", frame_err, 0);
        cpb = 16'(BIT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
